// File: rtl/register_block.sv
// Banked SIMT register file: 8 warps x 8 lanes x NUM_REGS entries.
// Two combinational read ports per lane, one clocked write per lane.
module register_block #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  localparam int WW = $clog2(NUM_WARPS),
  localparam int AW = $clog2(NUM_REGS),
  localparam int NL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WW-1:0]     warp_selector,
  input  logic [NL-1:0]     write_en,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic [DATA_W-1:0] wdata_2,
  input  logic [DATA_W-1:0] wdata_3,
  input  logic [DATA_W-1:0] wdata_4,
  input  logic [DATA_W-1:0] wdata_5,
  input  logic [DATA_W-1:0] wdata_6,
  input  logic [DATA_W-1:0] wdata_7,
  input  logic [NL-1:0]     read_en_0,
  input  logic [AW-1:0]     raddr_0,
  input  logic [NL-1:0]     read_en_1,
  input  logic [AW-1:0]     raddr_1,
  output logic [DATA_W-1:0] rdata_0_0,
  output logic [DATA_W-1:0] rdata_0_1,
  output logic [DATA_W-1:0] rdata_0_2,
  output logic [DATA_W-1:0] rdata_0_3,
  output logic [DATA_W-1:0] rdata_0_4,
  output logic [DATA_W-1:0] rdata_0_5,
  output logic [DATA_W-1:0] rdata_0_6,
  output logic [DATA_W-1:0] rdata_0_7,
  output logic [DATA_W-1:0] rdata_1_0,
  output logic [DATA_W-1:0] rdata_1_1,
  output logic [DATA_W-1:0] rdata_1_2,
  output logic [DATA_W-1:0] rdata_1_3,
  output logic [DATA_W-1:0] rdata_1_4,
  output logic [DATA_W-1:0] rdata_1_5,
  output logic [DATA_W-1:0] rdata_1_6,
  output logic [DATA_W-1:0] rdata_1_7
);

  logic [DATA_W-1:0] mem_q [NUM_WARPS][NL][NUM_REGS];
  logic [DATA_W-1:0] wdata [NL];
  logic [DATA_W-1:0] rd0   [NL];
  logic [DATA_W-1:0] rd1   [NL];

  assign wdata[0] = wdata_0;
  assign wdata[1] = wdata_1;
  assign wdata[2] = wdata_2;
  assign wdata[3] = wdata_3;
  assign wdata[4] = wdata_4;
  assign wdata[5] = wdata_5;
  assign wdata[6] = wdata_6;
  assign wdata[7] = wdata_7;

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++)
        for (int l = 0; l < NL; l++)
          for (int r = 0; r < NUM_REGS; r++)
            mem_q[w][l][r] <= '0;
    end else begin
      for (int l = 0; l < NL; l++)
        if (write_en[l])
          mem_q[warp_selector][l][waddr] <= wdata[l];
    end
  end

  for (genvar l = 0; l < NL; l++) begin : g_rd
    assign rd0[l] = read_en_0[l] ?
      mem_q[warp_selector][l][raddr_0] : '0;
    assign rd1[l] = read_en_1[l] ?
      mem_q[warp_selector][l][raddr_1] : '0;
  end

  assign rdata_0_0 = rd0[0];
  assign rdata_0_1 = rd0[1];
  assign rdata_0_2 = rd0[2];
  assign rdata_0_3 = rd0[3];
  assign rdata_0_4 = rd0[4];
  assign rdata_0_5 = rd0[5];
  assign rdata_0_6 = rd0[6];
  assign rdata_0_7 = rd0[7];
  assign rdata_1_0 = rd1[0];
  assign rdata_1_1 = rd1[1];
  assign rdata_1_2 = rd1[2];
  assign rdata_1_3 = rd1[3];
  assign rdata_1_4 = rd1[4];
  assign rdata_1_5 = rd1[5];
  assign rdata_1_6 = rd1[6];
  assign rdata_1_7 = rd1[7];

endmodule

// File: tb/tb_register_block.sv
// Directed bench for register_block: reset, per-port reads, sweep,
// warp isolation, lane masking, write/read ordering.
module tb_register_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ws;
  logic [7:0]  we;
  logic [4:0]  wa;
  logic [31:0] wd  [8];
  logic [7:0]  re0, re1;
  logic [4:0]  ra0, ra1;
  logic [31:0] rd0 [8];
  logic [31:0] rd1 [8];

  logic [31:0] last [8];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_block dut (
    .clk(clk), .rst(rst), .warp_selector(ws),
    .write_en(we), .waddr(wa),
    .wdata_0(wd[0]), .wdata_1(wd[1]),
    .wdata_2(wd[2]), .wdata_3(wd[3]),
    .wdata_4(wd[4]), .wdata_5(wd[5]),
    .wdata_6(wd[6]), .wdata_7(wd[7]),
    .read_en_0(re0), .raddr_0(ra0),
    .read_en_1(re1), .raddr_1(ra1),
    .rdata_0_0(rd0[0]), .rdata_0_1(rd0[1]),
    .rdata_0_2(rd0[2]), .rdata_0_3(rd0[3]),
    .rdata_0_4(rd0[4]), .rdata_0_5(rd0[5]),
    .rdata_0_6(rd0[6]), .rdata_0_7(rd0[7]),
    .rdata_1_0(rd1[0]), .rdata_1_1(rd1[1]),
    .rdata_1_2(rd1[2]), .rdata_1_3(rd1[3]),
    .rdata_1_4(rd1[4]), .rdata_1_5(rd1[5]),
    .rdata_1_6(rd1[6]), .rdata_1_7(rd1[7])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect: port p lanes read exp[i] where enabled, else 0.
  task automatic chk_ports(input string tag,
                           input logic [31:0] e0 [8],
                           input logic [31:0] e1 [8]);
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s p0 l%0d", tag, i), rd0[i], e0[i]);
      chk($sformatf("%s p1 l%0d", tag, i), rd1[i], e1[i]);
    end
  endtask

  logic [31:0] z [8];
  logic [31:0] e [8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      z[i] = '0; wd[i] = '0;
    end
    rst = 1'b1; ws = '0; we = '0; wa = '0;
    re0 = '0; re1 = '0; ra0 = '0; ra1 = '0;
    tick();
    rst = 1'b0;

    // reset state
    re0 = 8'hFF; re1 = 8'hFF; ra0 = 5'd3; ra1 = 5'd17;
    chk_ports("reset", z, z);

    // warp 0 reg 0, all lanes
    re0 = '0; re1 = '0;
    for (int i = 0; i < 8; i++) wd[i] = 32'h1000_0000 + i;
    we = 8'hFF; wa = 5'd0;
    tick();
    we = '0;
    for (int i = 0; i < 8; i++) e[i] = 32'h1000_0000 + i;
    re0 = 8'hFF; ra0 = 5'd0;
    chk_ports("w0r0 port0", e, z);
    re0 = '0; re1 = 8'hFF; ra1 = 5'd0;
    chk_ports("w0r0 port1", z, e);
    re0 = 8'hFF;
    chk_ports("w0r0 both", e, e);

    // full sweep
    for (int w = 0; w < 8; w++)
      for (int r = 0; r < 32; r++)
        for (int k = 0; k < 10; k++) begin
          ws = w[2:0]; wa = r[4:0]; we = 8'hFF;
          re0 = '0; re1 = '0;
          for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom;
            last[i] = wd[i];
          end
          tick();
          we = '0;
          ra0 = r[4:0]; ra1 = r[4:0];
          re0 = 8'hFF;
          chk_ports("sweep p0", last, z);
          re0 = '0; re1 = 8'hFF;
          chk_ports("sweep p1", z, last);
          re0 = 8'hFF;
          chk_ports("sweep both", last, last);
        end

    // reset with a concurrent write: write dropped, all cleared
    ws = 3'd0; wa = 5'd0; we = 8'hFF; rst = 1'b1;
    for (int i = 0; i < 8; i++) wd[i] = 32'h5555_0000 + i;
    tick();
    rst = 1'b0; we = '0;
    re0 = 8'hFF; re1 = 8'hFF; ra0 = 5'd0; ra1 = 5'd31;
    chk_ports("post-reset w0", z, z);
    ws = 3'd7; ra0 = 5'd9;
    chk_ports("post-reset w7", z, z);

    // warp isolation
    re0 = '0; re1 = '0;
    ws = 3'd2; wa = 5'd5; we = 8'hFF;
    for (int i = 0; i < 8; i++) wd[i] = 32'hAAAA_AAAA;
    tick();
    we = '0;
    ws = 3'd3; re0 = 8'hFF; ra0 = 5'd5; re1 = '0;
    chk_ports("iso w3", z, z);
    ws = 3'd2;
    for (int i = 0; i < 8; i++) e[i] = 32'hAAAA_AAAA;
    chk_ports("iso w2", e, z);

    // lane masking
    re0 = '0;
    wa = 5'd9; we = 8'h0F;
    for (int i = 0; i < 8; i++) wd[i] = 32'hFFFF_FFFF;
    tick();
    we = '0;
    re0 = 8'hFF; ra0 = 5'd9;
    for (int i = 0; i < 8; i++)
      e[i] = (i < 4) ? 32'hFFFF_FFFF : 32'h0;
    chk_ports("mask we", e, z);
    re0 = 8'h01;
    for (int i = 0; i < 8; i++)
      e[i] = (i == 0) ? 32'hFFFF_FFFF : 32'h0;
    chk_ports("mask re", e, z);

    // same-cycle write/read: no bypass
    re0 = '0;
    wa = 5'd7; we = 8'hFF;
    for (int i = 0; i < 8; i++) wd[i] = 32'h1;
    tick();
    for (int i = 0; i < 8; i++) wd[i] = 32'h2;
    re0 = 8'hFF; ra0 = 5'd7;
    for (int i = 0; i < 8; i++) e[i] = 32'h1;
    chk_ports("rw before", e, z);
    tick();
    we = '0;
    for (int i = 0; i < 8; i++) e[i] = 32'h2;
    chk_ports("rw after", e, z);

    // write under reset ignored
    rst = 1'b1; we = 8'hFF;
    for (int i = 0; i < 8; i++) wd[i] = 32'h3;
    tick();
    rst = 1'b0; we = '0;
    chk_ports("rst write", z, z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
